// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the nibble-serial ALU sequencer and its 4-bit slice.
package alu_seq_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ula_74181.sv
// Combinational 74181-compatible 4-bit ALU slice (active-high data, Cn/Cn+4 active-low).
module ula_74181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       a_eq_b,
    output logic       c_out
);

    logic [3:0] t1_s;
    logic [3:0] t2_s;
    logic [4:0] sum_s;

    // t1 acts as propagate and t2 as generate; logic mode is the complemented half-sum.
    always_comb begin
        t1_s  = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        t2_s  = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum_s = {1'b0, t1_s} + {1'b0, t2_s} + {4'b0000, ~c_in};
        if (m) begin
            f = ~(t1_s ^ t2_s);
        end else begin
            f = sum_s[3:0];
        end
        c_out  = ~sum_s[4];
        a_eq_b = &f;
    end

endmodule

// File: rtl/ula_8bit_nibble_seq.sv
// 8-bit ALU built by running one external 74181-style slice twice (low nibble, then high).
// Optional macro ALU_SEQ_PIPE_EN lets DONE accept the next request during the response handshake.
module ula_8bit_nibble_seq
    import alu_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WORD_W-1:0]   req_a,
    input  logic [WORD_W-1:0]   req_b,
    input  logic [3:0]          req_s,
    input  logic                req_m,
    input  logic                req_c_in,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORD_W-1:0]   rsp_f,
    output logic                rsp_c_out,
    output logic                rsp_a_eq_b,
    output logic [NIBBLE_W-1:0] slice_a,
    output logic [NIBBLE_W-1:0] slice_b,
    output logic [3:0]          slice_s,
    output logic                slice_m,
    output logic                slice_c_in,
    input  logic [NIBBLE_W-1:0] slice_f,
    input  logic                slice_a_eq_b,
    input  logic                slice_c_out
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LO   = LO;
    localparam logic [1:0] ST_HI   = HI;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]          state_r;
    logic [WORD_W-1:0]   a_r;
    logic [WORD_W-1:0]   b_r;
    logic [3:0]          s_r;
    logic                m_r;
    logic                c_in_r;
    logic [NIBBLE_W-1:0] f_lo_r;
    logic                carry_r;
    logic                eq_lo_r;
    logic [WORD_W-1:0]   rsp_f_r;
    logic                rsp_c_out_r;
    logic                rsp_a_eq_b_r;

    assign rsp_valid  = (state_r == ST_DONE);
    assign rsp_f      = rsp_f_r;
    assign rsp_c_out  = rsp_c_out_r;
    assign rsp_a_eq_b = rsp_a_eq_b_r;

    // Sequencer state, operand latches, inter-nibble carry and the response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            a_r          <= 8'h00;
            b_r          <= 8'h00;
            s_r          <= 4'h0;
            m_r          <= 1'b0;
            c_in_r       <= 1'b0;
            f_lo_r       <= 4'h0;
            carry_r      <= 1'b0;
            eq_lo_r      <= 1'b0;
            rsp_f_r      <= 8'h00;
            rsp_c_out_r  <= 1'b0;
            rsp_a_eq_b_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_r     <= req_a;
                        b_r     <= req_b;
                        s_r     <= req_s;
                        m_r     <= req_m;
                        c_in_r  <= req_c_in;
                        state_r <= ST_LO;
                    end
                end
                ST_LO: begin
                    f_lo_r  <= slice_f;
                    carry_r <= slice_c_out;
                    eq_lo_r <= slice_a_eq_b;
                    state_r <= ST_HI;
                end
                ST_HI: begin
                    rsp_f_r      <= {slice_f, f_lo_r};
                    rsp_c_out_r  <= slice_c_out;
                    rsp_a_eq_b_r <= eq_lo_r & slice_a_eq_b;
                    state_r      <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
`ifdef ALU_SEQ_PIPE_EN
                        if (req_valid) begin
                            a_r     <= req_a;
                            b_r     <= req_b;
                            s_r     <= req_s;
                            m_r     <= req_m;
                            c_in_r  <= req_c_in;
                            state_r <= ST_LO;
                        end else begin
                            state_r <= ST_IDLE;
                        end
`else
                        state_r <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Slice drive per phase (zero when not computing) and request acceptance.
    always_comb begin
        req_ready  = 1'b0;
        slice_a    = 4'h0;
        slice_b    = 4'h0;
        slice_s    = 4'h0;
        slice_m    = 1'b0;
        slice_c_in = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_LO: begin
                slice_a    = a_r[3:0];
                slice_b    = b_r[3:0];
                slice_s    = s_r;
                slice_m    = m_r;
                slice_c_in = c_in_r;
            end
            ST_HI: begin
                slice_a    = a_r[7:4];
                slice_b    = b_r[7:4];
                slice_s    = s_r;
                slice_m    = m_r;
                slice_c_in = carry_r;
            end
            ST_DONE: begin
`ifdef ALU_SEQ_PIPE_EN
                req_ready = rsp_ready;
`else
                req_ready = 1'b0;
`endif
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule
